// File: rtl/base_credit_arb_pkg.sv
// Shared types and helpers for the credit-pool arbiter.
package base_credit_pkg;

    // Controller states; the 2-bit encoding is part of the block's contract.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Requester id width; never below one bit so a 1-requester build still elaborates.
    function automatic int calc_idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/base_credit_arb_if.sv
// Requester/owner-facing bus of the credit-pool arbiter.
interface base_credit_arb_if
    import base_credit_pkg::*;
#(
    parameter int ways  = 4,
    parameter int width = 4,
    parameter int idw   = calc_idw(ways)
);
    logic             i_init_v;
    logic [width-1:0] i_init_d;
    logic [ways-1:0]  i_req;
    logic [ways-1:0]  o_gnt;
    logic [idw-1:0]   o_gnt_id;
    logic             i_ret;
    logic             i_drain;
    logic             o_drained;
    logic [width-1:0] o_cnt;
    logic             o_err;

    // Arbiter side.
    modport slave (
        input  i_init_v, i_init_d, i_req, i_ret, i_drain,
        output o_gnt, o_gnt_id, o_drained, o_cnt, o_err
    );

    // Owner / requester side.
    modport master (
        output i_init_v, i_init_d, i_req, i_ret, i_drain,
        input  o_gnt, o_gnt_id, o_drained, o_cnt, o_err
    );
endinterface

// File: rtl/base_incdec.sv
// Loadable up/down counter; simultaneous inc and dec cancel out.
module base_incdec #(
    parameter int               width = 4,
    parameter logic [width-1:0] rstv  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_v,
    input  logic [width-1:0] set_d,
    input  logic             inc,
    input  logic             dec,
    output logic [width-1:0] cnt_o
);
    logic [width-1:0] cnt_q;
    logic [width-1:0] cnt_d;

    // Load has priority; otherwise step by +1/-1 only when exactly one of inc/dec is set.
    always_comb begin
        cnt_d = cnt_q;
        if (set_v) begin
            cnt_d = set_d;
        end else if (inc && !dec) begin
            cnt_d = cnt_q + width'(1);
        end else if (dec && !inc) begin
            cnt_d = cnt_q - width'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= rstv;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/base_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module base_rr_pick #(
    parameter int ways = 4,
    parameter int idw  = 2
) (
    input  logic [ways-1:0] req_i,
    input  logic [idw-1:0]  ptr_i,
    output logic [ways-1:0] gnt_o,
    output logic [idw-1:0]  id_o,
    output logic            vld_o
);
    logic [2*ways-1:0] dbl_w;
    logic [ways-1:0]   rot_w;
    logic [idw-1:0]    off_w;
    logic [idw:0]      sum_w;

    // Rotating a doubled copy puts the pointer position at bit 0.
    assign dbl_w = {req_i, req_i};
    assign rot_w = ways'(dbl_w >> ptr_i);

    // Lowest set bit of the rotated vector is the winner's distance from ptr.
    always_comb begin
        vld_o = 1'b0;
        off_w = '0;
        for (int k = ways - 1; k >= 0; k--) begin
            if (rot_w[k]) begin
                vld_o = 1'b1;
                off_w = idw'(k);
            end
        end
    end

    // Map the offset back to an absolute index, wrapping modulo ways.
    always_comb begin
        sum_w = {1'b0, ptr_i} + {1'b0, off_w};
        if (sum_w >= (idw + 1)'(ways)) begin
            id_o = idw'(sum_w - (idw + 1)'(ways));
        end else begin
            id_o = sum_w[idw-1:0];
        end
    end

    for (genvar gi = 0; gi < ways; gi++) begin : g_onehot
        assign gnt_o[gi] = vld_o && (id_o == idw'(gi));
    end
endmodule

// File: rtl/base_credit_arb.sv
// Shared credit pool: round-robin credit grants, credit returns, drain-before-reconfig.
module base_credit_arb
    import base_credit_pkg::*;
#(
    parameter int ways  = 4,
    parameter int width = 4,
    parameter int idw   = calc_idw(ways)
) (
    input  logic              clk,
    input  logic              reset,
    base_credit_arb_if.slave  bus
);
    arb_state_t       state_q, state_d;
    logic [width-1:0] max_q, max_d;
    logic [idw-1:0]   rr_q, rr_d;
    logic             err_q, err_d;

    logic [width-1:0] cnt_w;
    logic [ways-1:0]  pick_gnt_w;
    logic [idw-1:0]   pick_id_w;
    logic             pick_vld_w;

    logic grant_en_w;
    logic any_gnt_w;
    logic init_ok_w;
    logic init_bad_w;
    logic overflow_w;
    logic inc_w;

    base_rr_pick #(
        .ways (ways),
        .idw  (idw)
    ) u_pick (
        .req_i (bus.i_req),
        .ptr_i (rr_q),
        .gnt_o (pick_gnt_w),
        .id_o  (pick_id_w),
        .vld_o (pick_vld_w)
    );

    base_incdec #(
        .width (width),
        .rstv  ({width{1'b0}})
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .set_v (init_ok_w),
        .set_d (bus.i_init_d),
        .inc   (inc_w),
        .dec   (any_gnt_w),
        .cnt_o (cnt_w)
    );

    // Grant qualification, error sources and counter enables.
    always_comb begin
        grant_en_w = (state_q == ST_RUN) && (cnt_w != '0);
        any_gnt_w  = grant_en_w && pick_vld_w;
        init_ok_w  = bus.i_init_v && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        init_bad_w = bus.i_init_v && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
        // A return with the pool already full is only legal if a credit leaves in the same cycle.
        overflow_w = bus.i_ret && (cnt_w == max_q) && !any_gnt_w;
        inc_w      = bus.i_ret && !overflow_w && (state_q != ST_IDLE);
    end

    // Next state for FSM, pool size, rr pointer and sticky error.
    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        rr_d    = rr_q;
        err_d   = err_q | init_bad_w | overflow_w | (bus.i_ret && (state_q == ST_IDLE));

        if (init_ok_w) begin
            max_d = bus.i_init_d;
        end

        if (any_gnt_w) begin
            rr_d = (pick_id_w == idw'(ways - 1)) ? '0 : pick_id_w + idw'(1);
        end

        unique case (state_q)
            ST_IDLE:  if (init_ok_w)         state_d = ST_RUN;
            ST_RUN:   if (bus.i_drain)       state_d = ST_DRAIN;
            ST_DRAIN: if (cnt_w == max_q)    state_d = ST_DONE;
            ST_DONE:  if (init_ok_w)         state_d = ST_RUN;
            default:                         state_d = ST_IDLE;
        endcase
    end

    // State, pool size, rr pointer and error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            max_q   <= '0;
            rr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_gnt     = grant_en_w ? pick_gnt_w : '0;
    assign bus.o_gnt_id  = any_gnt_w  ? pick_id_w  : '0;
    assign bus.o_cnt     = cnt_w;
    assign bus.o_drained = (state_q == ST_DONE);
    assign bus.o_err     = err_q;
endmodule
